// File: rtl/uart_tx_fifo_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : uart_tx_fifo_ctrl
// Brief    : CPU-writable byte FIFO with a status register, drained into a
//            UART transmitter through a tx_start / tx_busy handshake.
// Revision : 1.0
// ============================================================================
module uart_tx_fifo_ctrl #(
    parameter int DEPTH = 16,
    parameter int PTR_W = 4
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        sel,
    input  logic        we,
    input  logic [3:0]  addr,
    input  logic [31:0] wdata,
    output logic [31:0] rdata,
    output logic        tx_start,
    output logic [7:0]  tx_data,
    input  logic        tx_busy
);

    typedef enum logic [1:0] {
        S_IDLE      = 2'd0,
        S_WAIT_BUSY = 2'd1,
        S_WAIT_DONE = 2'd2
    } state_t;

    localparam logic [3:0]     c_ADDR_DATA   = 4'h0;
    localparam logic [3:0]     c_ADDR_STATUS = 4'h4;
    localparam logic [PTR_W:0] c_DEPTH       = (PTR_W + 1)'(DEPTH);

    logic [7:0]     r_mem [DEPTH];
    logic [PTR_W-1:0] r_wr_ptr;
    logic [PTR_W-1:0] r_rd_ptr;
    logic [PTR_W:0] r_count;
    logic           r_overflow;
    logic           r_tx_start;
    logic [7:0]     r_tx_data;
    state_t         r_state;
    state_t         w_next;

    logic w_full;
    logic w_empty;
    logic w_wr_data;
    logic w_push;
    logic w_pop;
    logic w_clr_ovf;
    logic w_active;
    logic w_unused;

    // Flags come from the pre-edge count, so a push while full is dropped
    // even if a pop retires an entry on the same edge.
    assign w_full    = (r_count == c_DEPTH);
    assign w_empty   = (r_count == '0);
    assign w_wr_data = sel && we && (addr == c_ADDR_DATA);
    assign w_push    = w_wr_data && !w_full;
    assign w_clr_ovf = sel && we && (addr == c_ADDR_STATUS) && wdata[3];
    assign w_active  = (r_state != S_IDLE) || tx_busy;
    assign w_unused  = ^{wdata[31:8], wdata[2:0]};

    assign tx_start = r_tx_start;
    assign tx_data  = r_tx_data;

    always_comb begin
        w_next = r_state;
        w_pop  = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (!w_empty && !tx_busy) begin
                    w_pop  = 1'b1;
                    w_next = S_WAIT_BUSY;
                end
            end
            // Blocks a second start until the transmitter has raised busy.
            S_WAIT_BUSY: if (tx_busy)  w_next = S_WAIT_DONE;
            S_WAIT_DONE: if (!tx_busy) w_next = S_IDLE;
            default:     w_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state    <= S_IDLE;
            r_wr_ptr   <= '0;
            r_rd_ptr   <= '0;
            r_count    <= '0;
            r_overflow <= 1'b0;
            r_tx_start <= 1'b0;
            r_tx_data  <= 8'h00;
        end else begin
            r_state    <= w_next;
            r_tx_start <= w_pop;
            if (w_pop) begin
                r_tx_data <= r_mem[r_rd_ptr];
                r_rd_ptr  <= r_rd_ptr + 1'b1;
            end
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + 1'b1;
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
            if (w_wr_data && w_full) begin
                r_overflow <= 1'b1;
            end else if (w_clr_ovf) begin
                r_overflow <= 1'b0;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem[r_wr_ptr] <= wdata[7:0];
        end
    end

    always_comb begin
        rdata = '0;
        if (addr == c_ADDR_STATUS) begin
            rdata[0]             = w_full;
            rdata[1]             = w_empty;
            rdata[2]             = w_active;
            rdata[3]             = r_overflow;
            rdata[4 +: PTR_W+1]  = r_count;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_uart_tx_fifo_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_uart_tx_fifo_ctrl
// Brief    : Bench for uart_tx_fifo_ctrl with a transmitter model and a
//            byte scoreboard checked by an independent monitor.
// Revision : 1.0
// ============================================================================
module tb_uart_tx_fifo_ctrl;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        sel;
    logic        we;
    logic [3:0]  addr;
    logic [31:0] wdata;
    logic [31:0] rdata;
    logic        tx_start;
    logic [7:0]  tx_data;
    logic        tx_busy;

    logic        hold_busy;
    logic        m_busy;
    int          m_st;
    int          m_cnt;
    int          busy_lag;
    int          frame_cycles;

    logic [7:0]  exp_q [$];
    int          n_cmp = 0;
    int          n_err = 0;

    assign tx_busy = hold_busy | m_busy;

    always #5 clk = ~clk;

    uart_tx_fifo_ctrl #(.DEPTH(16), .PTR_W(4)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .sel      (sel),
        .we       (we),
        .addr     (addr),
        .wdata    (wdata),
        .rdata    (rdata),
        .tx_start (tx_start),
        .tx_data  (tx_data),
        .tx_busy  (tx_busy)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    // Transmitter model: busy rises busy_lag cycles after it sees tx_start
    // and stays high for frame_cycles cycles.
    initial begin
        m_busy = 1'b0;
        m_st   = 0;
        m_cnt  = 0;
        forever begin
            @(negedge clk);
            if (rst_n !== 1'b1) begin
                m_st   = 0;
                m_busy = 1'b0;
            end else begin
                case (m_st)
                    0: if (tx_start === 1'b1) begin
                        m_cnt = busy_lag;
                        m_st  = 1;
                    end
                    1: begin
                        m_cnt--;
                        if (m_cnt <= 0) begin
                            m_busy = 1'b1;
                            m_cnt  = frame_cycles;
                            m_st   = 2;
                        end
                    end
                    default: begin
                        m_cnt--;
                        if (m_cnt <= 0) begin
                            m_busy = 1'b0;
                            m_st   = 0;
                        end
                    end
                endcase
            end
        end
    end

    // Monitor: every start pulse is matched against the next expected byte.
    initial begin
        logic [7:0] exp_b;
        forever begin
            @(negedge clk);
            if (rst_n === 1'b1 && tx_start === 1'b1) begin
                check("start_while_busy", 32'(tx_busy), 32'd0);
                if (exp_q.size() == 0) begin
                    n_cmp++;
                    n_err++;
                    $display("FAIL unexpected_start: got tx_data 0x%0h expected no pulse", tx_data);
                end else begin
                    exp_b = exp_q.pop_front();
                    check("tx_data_order", 32'(tx_data), 32'(exp_b));
                end
            end
        end
    end

    task automatic bus_write(input logic [3:0] a, input logic [31:0] d);
        sel   = 1'b1;
        we    = 1'b1;
        addr  = a;
        wdata = d;
        @(posedge clk);
        #1;
        sel   = 1'b0;
        we    = 1'b0;
        addr  = 4'h0;
        wdata = '0;
    endtask

    task automatic bus_read(input string name, input logic [3:0] a, input logic [31:0] exp);
        sel  = 1'b1;
        we   = 1'b0;
        addr = a;
        #1;
        check(name, rdata, exp);
        sel  = 1'b0;
        addr = 4'h0;
    endtask

    task automatic push_byte(input logic [7:0] b);
        exp_q.push_back(b);
        bus_write(4'h0, {24'hA5A5A5, b});
    endtask

    task automatic wait_drain(input string name);
        int t = 0;
        while ((exp_q.size() != 0 || tx_busy || m_st != 0 || tx_start) && t < 3000) begin
            @(posedge clk);
            #1;
            t++;
        end
        repeat (4) @(posedge clk);
        #1;
        check(name, 32'(exp_q.size()), 32'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        rst_n        = 1'b0;
        sel          = 1'b0;
        we           = 1'b0;
        addr         = 4'h0;
        wdata        = '0;
        hold_busy    = 1'b0;
        busy_lag     = 1;
        frame_cycles = 10;
        repeat (2) @(posedge clk);
        #1;
        check("rst_tx_start", 32'(tx_start), 32'd0);
        check("rst_tx_data", 32'(tx_data), 32'd0);
        bus_read("rst_status", 4'h4, 32'h002);
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        // Single byte: pulse two edges after the push, count 1 then 0.
        exp_q.push_back(8'h41);
        bus_write(4'h0, 32'hABCD_EE41);
        check("lat_edge1", 32'(tx_start), 32'd0);
        bus_read("status_cnt1", 4'h4, 32'h010);
        @(posedge clk);
        #1;
        check("lat_edge2", 32'(tx_start), 32'd1);
        check("lat_data", 32'(tx_data), 32'h41);
        repeat (20) @(posedge clk);
        #1;
        wait_drain("drain_single");
        bus_read("status_idle1", 4'h4, 32'h002);

        // Reserved offset and DATA reads.
        bus_write(4'h8, 32'h0000_0055);
        bus_read("reserved_read", 4'h8, 32'h0);
        bus_read("data_read", 4'h0, 32'h0);
        bus_read("status_after_rsvd", 4'h4, 32'h002);

        // Burst to full with busy held, overflow, overflow clear.
        hold_busy    = 1'b1;
        frame_cycles = 3;
        for (int i = 0; i < 16; i++) begin
            push_byte(8'(8'h10 + i));
        end
        bus_read("status_full", 4'h4, 32'h105);
        bus_write(4'h0, 32'h0000_00FF);
        bus_read("status_overflow", 4'h4, 32'h10D);
        bus_write(4'h4, 32'h0000_0008);
        bus_read("status_ovf_clr", 4'h4, 32'h105);
        hold_busy = 1'b0;
        wait_drain("drain_burst");
        bus_read("status_idle2", 4'h4, 32'h002);

        // Simultaneous push and pop with three entries queued.
        hold_busy = 1'b1;
        push_byte(8'hA0);
        push_byte(8'hA1);
        push_byte(8'hA2);
        bus_read("status_cnt3", 4'h4, 32'h034);
        hold_busy = 1'b0;
        push_byte(8'hA3);
        bus_read("status_pushpop", 4'h4, 32'h034);
        wait_drain("drain_wrap");
        bus_read("status_idle3", 4'h4, 32'h002);

        // Late busy from the transmitter must not produce an extra pulse.
        busy_lag = 2;
        push_byte(8'hB0);
        push_byte(8'hB1);
        wait_drain("drain_late_busy");
        bus_read("status_idle4", 4'h4, 32'h002);
        busy_lag = 1;

        // Reset while a start pulse is high discards the queue.
        frame_cycles = 5;
        push_byte(8'hC0);
        push_byte(8'hC1);
        for (int t = 0; t < 20 && tx_start !== 1'b1; t++) begin
            @(posedge clk);
            #1;
        end
        check("mid_start_seen", 32'(tx_start), 32'd1);
        rst_n = 1'b0;
        #1;
        check("mid_rst_tx_start", 32'(tx_start), 32'd0);
        exp_q.delete();
        bus_read("mid_rst_status", 4'h4, 32'h002);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        check("mid_rst_tx_data", 32'(tx_data), 32'd0);
        @(posedge clk);
        #1;
        push_byte(8'h5A);
        wait_drain("drain_after_rst");
        bus_read("status_final", 4'h4, 32'h002);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
`default_nettype wire
